// File: rtl/pmu_ahb_pkg.sv
// Shared definitions for the PMU: register map indices, selector width, AHB encodings.
package pmu_ahb_pkg;

  localparam int unsigned IDX_W     = 10;
  localparam int unsigned SEL_W     = 5;
  localparam int unsigned SEL_PER_R = 6;

  localparam logic [IDX_W-1:0] IDX_CFG          = 10'd0;
  localparam logic [IDX_W-1:0] IDX_CNT_BASE     = 10'd1;
  localparam logic [IDX_W-1:0] IDX_SEL_BASE     = 10'd25;
  localparam logic [IDX_W-1:0] IDX_OVF_IE       = 10'd29;
  localparam logic [IDX_W-1:0] IDX_OVF_ST       = 10'd30;
  localparam logic [IDX_W-1:0] IDX_SCRATCH_BASE = 10'd31;

  localparam int unsigned CFG_EN_BIT      = 0;
  localparam int unsigned CFG_SOFTRST_BIT = 1;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

endpackage

// File: rtl/pmu_ahb_lite_if.sv
// AHB-Lite slave-side bus bundle for the PMU register window.
interface pmu_ahb_lite_if #(
  parameter int unsigned DW = 32
);
  logic          hsel;
  logic          hreadyi;
  logic [31:0]   haddr;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [3:0]    hprot;
  logic          hmastlock;
  logic          hreadyo;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;

  modport slave (
    input  hsel, hreadyi, haddr, hwrite, htrans, hsize, hburst, hwdata, hprot, hmastlock,
    output hreadyo, hresp, hrdata
  );

  modport master (
    output hsel, hreadyi, haddr, hwrite, htrans, hsize, hburst, hwdata, hprot, hmastlock,
    input  hreadyo, hresp, hrdata
  );
endinterface

// File: rtl/pmu_counter.sv
// Wrap-around event counter with soft clear, bus load and a same-cycle overflow strobe.
module pmu_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         ovf_c
);

  // Clear beats a bus load, which beats an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (clr)        count <= '0;
    else if (load)       count <= load_val;
    else if (en && inc)  count <= count + W'(1);
  end

  assign ovf_c = en && inc && !clr && !load && (count == '1);

endmodule

// File: rtl/pmu_ahb_lite.sv
// Performance monitoring unit: event counters, selectors and overflow interrupt behind
// a zero-wait-state AHB-Lite register window.
module pmu_ahb_lite
  import pmu_ahb_pkg::*;
#(
  parameter logic [31:0] haddr        = 32'h8010_0000,
  parameter logic [31:0] hmask        = 32'h0000_0fff,
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned N_REGS       = 47,
  parameter int unsigned N_COUNTERS   = 24,
  parameter int unsigned N_SOC_EV     = 32,
  parameter int unsigned MCCU_N_CORES = 4,
  parameter int unsigned FT           = 0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  pmu_ahb_lite_if.slave       bus,
  input  logic [N_SOC_EV-1:0] events_i,
  output logic                intr_overflow_o,
  output logic                intr_quota_o,
  output logic                intr_MCCU_o,
  output logic                intr_RDC_o,
  output logic                intr_FT1_o,
  output logic                intr_FT2_o
);

  localparam int unsigned N_SEL  = (N_COUNTERS + SEL_PER_R - 1) / SEL_PER_R;
  localparam int unsigned SEL_RW = SEL_PER_R * SEL_W;
  localparam int unsigned N_SCR  = N_REGS - 31;

  logic [1:0]            cfg;
  logic [SEL_RW-1:0]     sel_q   [N_SEL];
  logic [REG_WIDTH-1:0]  scratch [N_SCR];
  logic [REG_WIDTH-1:0]  cnt     [N_COUNTERS];
  logic [N_COUNTERS-1:0] ovf_ie;
  logic [N_COUNTERS-1:0] ovf_st;
  logic [N_COUNTERS-1:0] ovf_set;
  logic [N_COUNTERS-1:0] w1c;
  logic [REG_WIDTH-1:0]  hrdata_q;
  logic [REG_WIDTH-1:0]  rd_val;
  logic                  intr_q;

  logic             dp_valid;
  logic             dp_write;
  logic [IDX_W-1:0] dp_idx;
  logic             sel_c;
  logic [IDX_W-1:0] idx;
  logic             wr_en;
  logic             fwd;
  logic             cnt_en;
  logic             soft_rst;
  logic             unused;

  assign idx      = bus.haddr[IDX_W+1:2];
  assign sel_c    = bus.hsel && bus.hreadyi && bus.htrans[1] &&
                    ((bus.haddr & ~hmask) == (haddr & ~hmask));
  assign wr_en    = dp_valid && dp_write && (dp_idx < IDX_W'(N_REGS));
  assign fwd      = wr_en && (dp_idx == idx);
  assign soft_rst = cfg[CFG_SOFTRST_BIT];
  assign cnt_en   = cfg[CFG_EN_BIT] && !soft_rst;
  assign w1c      = (wr_en && dp_idx == IDX_OVF_ST) ? bus.hwdata[N_COUNTERS-1:0] : '0;

  assign bus.hreadyo = 1'b1;
  assign bus.hresp   = HRESP_OKAY;
  assign bus.hrdata  = hrdata_q;

  assign intr_overflow_o = intr_q;
  assign intr_quota_o    = 1'b0;
  assign intr_MCCU_o     = 1'b0;
  assign intr_RDC_o      = 1'b0;
  assign intr_FT1_o      = 1'b0;
  assign intr_FT2_o      = 1'b0;

  assign unused = ^{bus.hsize, bus.hburst, bus.hprot, bus.hmastlock, bus.haddr[1:0],
                    32'(MCCU_N_CORES), 32'(FT)};

  // Address phase capture and registered read data (with write-data forwarding).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      hrdata_q <= '0;
    end else begin
      dp_valid <= sel_c;
      if (sel_c) begin
        dp_write <= bus.hwrite;
        dp_idx   <= idx;
        if (!bus.hwrite) hrdata_q <= fwd ? bus.hwdata : rd_val;
      end
    end
  end

  // Read mux; anything not matched (including out-of-range) reads as zero.
  always_comb begin
    rd_val = '0;
    if (idx == IDX_CFG)    rd_val = REG_WIDTH'(cfg);
    if (idx == IDX_OVF_IE) rd_val = REG_WIDTH'(ovf_ie);
    if (idx == IDX_OVF_ST) rd_val = REG_WIDTH'(ovf_st);
    for (int j = 0; j < int'(N_COUNTERS); j++)
      if (idx == IDX_CNT_BASE + IDX_W'(j)) rd_val = cnt[j];
    for (int k = 0; k < int'(N_SEL); k++)
      if (idx == IDX_SEL_BASE + IDX_W'(k)) rd_val = REG_WIDTH'(sel_q[k]);
    for (int s = 0; s < int'(N_SCR); s++)
      if (idx == IDX_SCRATCH_BASE + IDX_W'(s)) rd_val = scratch[s];
  end

  // Software registers; SOFTRST only clears OVF_ST here, counters clear themselves.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg     <= '0;
      sel_q   <= '{default: '0};
      scratch <= '{default: '0};
      ovf_ie  <= '0;
      ovf_st  <= '0;
      intr_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        if (dp_idx == IDX_CFG)    cfg    <= bus.hwdata[1:0];
        if (dp_idx == IDX_OVF_IE) ovf_ie <= bus.hwdata[N_COUNTERS-1:0];
        for (int k = 0; k < int'(N_SEL); k++)
          if (dp_idx == IDX_SEL_BASE + IDX_W'(k)) sel_q[k] <= bus.hwdata[SEL_RW-1:0];
        for (int s = 0; s < int'(N_SCR); s++)
          if (dp_idx == IDX_SCRATCH_BASE + IDX_W'(s)) scratch[s] <= bus.hwdata;
      end
      if (soft_rst) ovf_st <= '0;
      else          ovf_st <= (ovf_st & ~w1c) | ovf_set;
      intr_q <= |(ovf_st & ovf_ie);
    end
  end

  for (genvar j = 0; j < int'(N_COUNTERS); j++) begin : g_cnt
    logic [SEL_W-1:0] ev_sel;
    logic             load;
    assign ev_sel = sel_q[j / SEL_PER_R][SEL_W * (j % SEL_PER_R) +: SEL_W];
    assign load   = wr_en && (dp_idx == IDX_CNT_BASE + IDX_W'(j));

    pmu_counter #(.W(REG_WIDTH)) u_cnt (
      .clk      (clk_i),
      .rst_n    (rstn_i),
      .en       (cnt_en),
      .clr      (soft_rst),
      .load     (load),
      .load_val (bus.hwdata),
      .inc      (events_i[ev_sel]),
      .count    (cnt[j]),
      .ovf_c    (ovf_set[j])
    );
  end

endmodule

// File: tb/tb_pmu_ahb_lite.sv
// Directed bench for pmu_ahb_lite: register access, counting, overflow, soft reset, reset.
module tb_pmu_ahb_lite;
  import pmu_ahb_pkg::*;

  localparam logic [31:0] BASE = 32'h8010_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] events;
  logic        intr_ovf, intr_quota, intr_mccu, intr_rdc, intr_ft1, intr_ft2;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rd;

  pmu_ahb_lite_if #(.DW(32)) bus ();

  pmu_ahb_lite dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .bus             (bus),
    .events_i        (events),
    .intr_overflow_o (intr_ovf),
    .intr_quota_o    (intr_quota),
    .intr_MCCU_o     (intr_mccu),
    .intr_RDC_o      (intr_rdc),
    .intr_FT1_o      (intr_ft1),
    .intr_FT2_o      (intr_ft2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int i);
    return BASE + 32'(i * 4);
  endfunction

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [1:0] tr);
    bus.hsel    = 1'b1;
    bus.hreadyi = 1'b1;
    bus.haddr   = a;
    bus.hwrite  = w;
    bus.htrans  = tr;
  endtask

  task automatic idle_bus();
    bus.hsel   = 1'b0;
    bus.hwrite = 1'b0;
    bus.htrans = HTRANS_IDLE;
  endtask

  task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] tr);
    @(negedge clk);
    addr_phase(a, 1'b1, tr);
    @(negedge clk);
    idle_bus();
    bus.hwdata = d;
    @(negedge clk);
  endtask

  task automatic ahb_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_phase(a, 1'b0, HTRANS_NONSEQ);
    @(negedge clk);
    idle_bus();
    d = bus.hrdata;
    chk("hreadyo", 32'(bus.hreadyo), 32'd1);
    chk("hresp", 32'(bus.hresp), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    events = '0;
    bus.hwdata = '0;
    bus.haddr = '0;
    bus.hsize = 3'b010;
    bus.hburst = '0;
    bus.hprot = '0;
    bus.hmastlock = 1'b0;
    bus.hreadyi = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset state
    chk("rst_hrdata", bus.hrdata, 32'h0);
    chk("rst_intr", 32'(intr_ovf), 32'h0);
    chk("tied_intr", 32'({intr_quota, intr_mccu, intr_rdc, intr_ft1, intr_ft2}), 32'h0);
    ahb_rd(ra(0), rd);  chk("rst_cfg", rd, 32'h0);
    ahb_rd(ra(1), rd);  chk("rst_cnt0", rd, 32'h0);

    // Counter 0 on event 0, all others on idle event 31
    ahb_wr(ra(25), 32'h3fff_ffe0, HTRANS_NONSEQ);
    for (int k = 26; k <= 28; k++) ahb_wr(ra(k), 32'h3fff_ffff, HTRANS_NONSEQ);
    ahb_wr(ra(0), 32'h2, HTRANS_NONSEQ);
    ahb_wr(ra(0), 32'h1, HTRANS_NONSEQ);
    @(negedge clk); events[0] = 1'b1;
    repeat (10) @(negedge clk);
    events = '0;
    ahb_rd(ra(1), rd);  chk("cnt0_10ev", rd, 32'd10);
    ahb_rd(ra(2), rd);  chk("cnt1_zero", rd, 32'd0);
    ahb_rd(ra(24), rd); chk("cnt23_zero", rd, 32'd0);

    // Scratch write/read
    ahb_wr(32'h8010_00ac, 32'hcafe_cafe, HTRANS_NONSEQ);
    ahb_rd(32'h8010_00ac, rd); chk("scratch43", rd, 32'hcafe_cafe);

    // Overflow on counter 2 via event 5
    ahb_wr(ra(3), 32'hffff_fffe, HTRANS_NONSEQ);
    ahb_wr(ra(25), 32'h3fff_97e0, HTRANS_NONSEQ);
    ahb_wr(ra(29), 32'h4, HTRANS_NONSEQ);
    ahb_rd(ra(3), rd);  chk("cnt2_load", rd, 32'hffff_fffe);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); events[5] = 1'b1;
      @(negedge clk); events[5] = 1'b0;
    end
    ahb_rd(ra(3), rd);  chk("cnt2_wrap", rd, 32'h0);
    ahb_rd(ra(30), rd); chk("ovf_st_set", rd, 32'h4);
    chk("intr_set", 32'(intr_ovf), 32'h1);
    ahb_wr(ra(30), 32'h4, HTRANS_NONSEQ);
    ahb_rd(ra(30), rd); chk("ovf_st_w1c", rd, 32'h0);
    chk("intr_clr", 32'(intr_ovf), 32'h0);

    // Random events then soft reset
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); events = $urandom;
    end
    @(negedge clk); events = '0;
    ahb_wr(ra(0), 32'h2, HTRANS_NONSEQ);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); events = $urandom;
    end
    ahb_rd(ra(1), rd);  chk("srst_cnt0", rd, 32'h0);
    ahb_rd(ra(3), rd);  chk("srst_cnt2", rd, 32'h0);
    ahb_rd(ra(24), rd); chk("srst_cnt23", rd, 32'h0);
    ahb_rd(ra(30), rd); chk("srst_ovf_st", rd, 32'h0);
    ahb_rd(ra(25), rd); chk("srst_sel_kept", rd, 32'h3fff_97e0);
    ahb_rd(ra(0), rd);  chk("srst_cfg_kept", rd, 32'h2);
    events = '0;
    ahb_wr(ra(0), 32'h0, HTRANS_NONSEQ);

    // Non-qualifying accesses
    ahb_wr(32'h8020_00b0, 32'h0000_1234, HTRANS_NONSEQ);
    ahb_rd(ra(44), rd); chk("out_window", rd, 32'h0);
    ahb_wr(ra(44), 32'h0000_5678, HTRANS_IDLE);
    ahb_rd(ra(44), rd); chk("idle_write", rd, 32'h0);
    ahb_wr(ra(50), 32'hdead_beef, HTRANS_NONSEQ);
    ahb_rd(ra(50), rd); chk("idx50_read", rd, 32'h0);
    ahb_rd(ra(43), rd); chk("scratch43_kept", rd, 32'hcafe_cafe);

    // Back-to-back write then read of the same index
    @(negedge clk); addr_phase(ra(45), 1'b1, HTRANS_NONSEQ);
    @(negedge clk); addr_phase(ra(45), 1'b0, HTRANS_NONSEQ); bus.hwdata = 32'h5a5a_1234;
    @(negedge clk); idle_bus();
    chk("fwd_read", bus.hrdata, 32'h5a5a_1234);
    ahb_rd(ra(45), rd); chk("fwd_stored", rd, 32'h5a5a_1234);

    // Reset during a write data phase
    @(negedge clk); addr_phase(ra(46), 1'b1, HTRANS_NONSEQ);
    @(negedge clk); idle_bus(); bus.hwdata = 32'hfeed_beef; rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_hrdata", bus.hrdata, 32'h0);
    chk("rst_mid_intr", 32'(intr_ovf), 32'h0);
    rstn = 1'b1;
    ahb_rd(ra(46), rd); chk("rst_mid_target", rd, 32'h0);
    ahb_rd(ra(43), rd); chk("rst_mid_scratch", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
